// File: rtl/psk_frame_pkg.sv
// Constants and types shared by the PSK Rx frame synchroniser and the Tx framer.
package psk_frame_pkg;

  localparam int unsigned SYNC_LEN_DEF      = 16;
  localparam logic [15:0] SYNC_WORD_DEF     = 16'hEB90;
  localparam int unsigned PAYLOAD_BYTES_DEF = 32;

  typedef enum logic {
    StHunt,
    StPayload
  } frame_state_e;

endpackage

// File: rtl/sync_correlator.sv
// Combinational Hamming distance of a candidate window against the sync word,
// in both polarities.
module sync_correlator
  import psk_frame_pkg::*;
#(
  parameter int unsigned         SYNC_LEN  = SYNC_LEN_DEF,
  parameter logic [SYNC_LEN-1:0] SYNC_WORD = SYNC_WORD_DEF,
  localparam int unsigned        DW        = $clog2(SYNC_LEN + 1)
) (
  input  logic [SYNC_LEN-1:0] sr_next,
  output logic [DW-1:0]       d0,
  output logic [DW-1:0]       d1
);

  logic [SYNC_LEN-1:0] diff;

  assign diff = sr_next ^ SYNC_WORD;

  // Popcount of the mismatch vector; the complemented distance follows directly.
  always_comb begin
    d0 = '0;
    for (int unsigned i = 0; i < SYNC_LEN; i++) begin
      d0 = d0 + DW'(diff[i]);
    end
    d1 = DW'(SYNC_LEN) - d0;
  end

endmodule

// File: rtl/rx_frame_sync.sv
// Receive frame synchroniser: hunts for the sync word (either polarity), then
// packs the fixed-length payload MSB-first into one-cycle byte strobes.
module rx_frame_sync
  import psk_frame_pkg::*;
#(
  parameter int unsigned         SYNC_LEN      = SYNC_LEN_DEF,
  parameter logic [SYNC_LEN-1:0] SYNC_WORD     = SYNC_WORD_DEF,
  parameter int unsigned         PAYLOAD_BYTES = PAYLOAD_BYTES_DEF,
  parameter int unsigned         MAX_ERR       = 1
) (
  input  logic       clk_1M024,
  input  logic       rst_n_1M024,
  input  logic       bit_in,
  input  logic       bit_vld,
  input  logic       sig_det,
  output logic [7:0] data_tdata,
  output logic       data_tvalid,
  output logic       data_tuser,
  output logic       data_tlast,
  output logic       locked,
  output logic       inverted,
  output logic       frame_abort
);

  localparam int unsigned DW = $clog2(SYNC_LEN + 1);
  localparam logic [DW-1:0] MaxErrW   = DW'(MAX_ERR);
  localparam logic [DW-1:0] FillFull  = DW'(SYNC_LEN);
  localparam logic [DW-1:0] FillLast  = DW'(SYNC_LEN - 1);
  localparam logic [7:0]    LastByte  = 8'(PAYLOAD_BYTES - 1);

  frame_state_e        state_q, state_d;
  logic [SYNC_LEN-1:0] sr_q, sr_d, sr_next;
  logic [DW-1:0]       fill_q, fill_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [7:0]          byte_cnt_q, byte_cnt_d;
  logic [7:0]          asm_q, asm_d, asm_next;
  logic                inv_q, inv_d;
  logic [7:0]          tdata_q, tdata_d;
  logic                tvalid_q, tvalid_d;
  logic                tuser_q, tuser_d;
  logic                tlast_q, tlast_d;
  logic                abort_q, abort_d;
  logic [DW-1:0]       d0, d1;

  assign sr_next  = {sr_q[SYNC_LEN-2:0], bit_in};
  assign asm_next = {asm_q[6:0], bit_in ^ inv_q};

  sync_correlator #(
    .SYNC_LEN  (SYNC_LEN),
    .SYNC_WORD (SYNC_WORD)
  ) u_corr (
    .sr_next (sr_next),
    .d0      (d0),
    .d1      (d1)
  );

  // Next-state and output decode for the HUNT/PAYLOAD machine.
  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    fill_d     = fill_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    inv_d      = inv_q;
    tdata_d    = tdata_q;
    tvalid_d   = 1'b0;
    tuser_d    = 1'b0;
    tlast_d    = 1'b0;
    abort_d    = 1'b0;

    unique case (state_q)
      StHunt: begin
        if (!sig_det) begin
          fill_d = '0;
        end else if (bit_vld) begin
          sr_d = sr_next;
          if (fill_q != FillFull) fill_d = fill_q + DW'(1);
          // A match needs a full window of bits received since entering HUNT.
          if (fill_q >= FillLast) begin
            if (d0 <= MaxErrW) begin
              state_d    = StPayload;
              inv_d      = 1'b0;
              bit_cnt_d  = '0;
              byte_cnt_d = '0;
            end else if (d1 <= MaxErrW) begin
              state_d    = StPayload;
              inv_d      = 1'b1;
              bit_cnt_d  = '0;
              byte_cnt_d = '0;
            end
          end
        end
      end

      StPayload: begin
        if (!sig_det) begin
          // Carrier lost: drop the partial byte and the rest of the frame.
          state_d    = StHunt;
          abort_d    = 1'b1;
          fill_d     = '0;
          bit_cnt_d  = '0;
          byte_cnt_d = '0;
        end else if (bit_vld) begin
          asm_d     = asm_next;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            tvalid_d = 1'b1;
            tdata_d  = asm_next;
            tuser_d  = (byte_cnt_q == 8'd0);
            tlast_d  = (byte_cnt_q == LastByte);
            if (byte_cnt_q == LastByte) begin
              state_d    = StHunt;
              fill_d     = '0;
              byte_cnt_d = '0;
            end else begin
              byte_cnt_d = byte_cnt_q + 8'd1;
            end
          end
        end
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_1M024 or negedge rst_n_1M024) begin
    if (!rst_n_1M024) begin
      state_q <= StHunt;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath, counters and registered outputs.
  always_ff @(posedge clk_1M024 or negedge rst_n_1M024) begin
    if (!rst_n_1M024) begin
      sr_q       <= '0;
      fill_q     <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      inv_q      <= 1'b0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tuser_q    <= 1'b0;
      tlast_q    <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      sr_q       <= sr_d;
      fill_q     <= fill_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      inv_q      <= inv_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      tuser_q    <= tuser_d;
      tlast_q    <= tlast_d;
      abort_q    <= abort_d;
    end
  end

  assign data_tdata  = tdata_q;
  assign data_tvalid = tvalid_q;
  assign data_tuser  = tuser_q;
  assign data_tlast  = tlast_q;
  assign locked      = (state_q == StPayload);
  assign inverted    = inv_q;
  assign frame_abort = abort_q;

endmodule

// File: tb/tb_rx_frame_sync.sv
// Directed-random bench for rx_frame_sync against a bit-stream reference model.
module tb_rx_frame_sync;

  localparam int P    = 4;
  localparam int MAXE = 1;
  localparam logic [15:0] SYNC = 16'hEB90;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bit_in = 1'b0;
  logic       bit_vld = 1'b0;
  logic       sig_det = 1'b1;
  logic [7:0] data_tdata;
  logic       data_tvalid, data_tuser, data_tlast, locked, inverted, frame_abort;

  int n_cmp = 0;
  int n_err = 0;
  int abort_cnt = 0;

  // Entries are {tuser, tlast, byte}.
  logic [9:0] got_q[$];
  logic [9:0] exp_q[$];
  logic [9:0] want_q[$];
  logic [9:0] m_q[$];
  bit         stream[$];
  bit         m_inv;

  always #5 clk = ~clk;

  rx_frame_sync #(
    .SYNC_LEN      (16),
    .SYNC_WORD     (SYNC),
    .PAYLOAD_BYTES (P),
    .MAX_ERR       (MAXE)
  ) dut (
    .clk_1M024   (clk),
    .rst_n_1M024 (rst_n),
    .bit_in      (bit_in),
    .bit_vld     (bit_vld),
    .sig_det     (sig_det),
    .data_tdata  (data_tdata),
    .data_tvalid (data_tvalid),
    .data_tuser  (data_tuser),
    .data_tlast  (data_tlast),
    .locked      (locked),
    .inverted    (inverted),
    .frame_abort (frame_abort)
  );

  // Output monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (data_tvalid) got_q.push_back({data_tuser, data_tlast, data_tdata});
    if (frame_abort) abort_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: slide a window over the whole stream; on a near match of either
  // polarity, the next P*8 bits are the frame, then hunting restarts from empty.
  function automatic void model(input bit b[$]);
    logic [15:0] w;
    logic [7:0]  by;
    int fill, i, d0;
    w = '0; fill = 0; i = 0;
    m_q.delete();
    while (i < b.size()) begin
      w = {w[14:0], 1'(b[i])};
      i++;
      if (fill < 16) fill++;
      if (fill == 16) begin
        d0 = $countones(w ^ SYNC);
        if (d0 <= MAXE || (16 - d0) <= MAXE) begin
          m_inv = (d0 > MAXE);
          for (int k = 0; k < P; k++) begin
            if (i + 8 > b.size()) return;
            by = '0;
            for (int j = 0; j < 8; j++) begin
              by = {by[6:0], 1'(b[i]) ^ m_inv};
              i++;
            end
            m_q.push_back({(k == 0), (k == P - 1), by});
          end
          fill = 0;
        end
      end
    end
  endfunction

  function automatic bit q_eq(input logic [9:0] a[$], input logic [9:0] b[$]);
    if (a.size() != b.size()) return 1'b0;
    foreach (a[j]) if (a[j] !== b[j]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void push_word(input logic [31:0] v, input int n);
    for (int j = n - 1; j >= 0; j--) stream.push_back(v[j]);
  endfunction

  function automatic void add_want(input logic [31:0] p, input int nbytes);
    for (int k = 0; k < nbytes; k++)
      want_q.push_back({(k == 0), (k == P - 1), p[31 - 8*k -: 8]});
  endfunction

  function automatic void make_stream(input logic [15:0] sync, input logic [31:0] p1,
                                      input int n1, input bit two, input logic [31:0] p2,
                                      input bit inv);
    stream.delete();
    for (int j = 0; j < 20; j++) stream.push_back(1'($urandom));
    push_word({16'h0, sync}, 16);
    push_word(p1 >> (32 - n1), n1);
    if (two) begin
      push_word({16'h0, SYNC}, 16);
      push_word(p2, 32);
    end
    if (inv) foreach (stream[j]) stream[j] = ~stream[j];
  endfunction

  // Re-roll the random prefix until the model sees exactly the intended frames.
  task automatic prepare(input logic [15:0] sync, input logic [31:0] p1, input int n1,
                         input bit two, input logic [31:0] p2, input bit inv);
    for (int t = 0; t < 100; t++) begin
      make_stream(sync, p1, n1, two, p2, inv);
      model(stream);
      if (q_eq(m_q, want_q)) break;
    end
    exp_q = m_q;
    got_q.delete();
    abort_cnt = 0;
  endtask

  task automatic drive(input bit gapped);
    foreach (stream[j]) begin
      bit_in = stream[j];
      bit_vld = 1'b1;
      @(posedge clk); #1;
      if (gapped) begin
        bit_vld = 1'b0;
        bit_in = 1'($urandom);
        @(posedge clk); #1;
      end
    end
    bit_vld = 1'b0;
  endtask

  task automatic compare_out(input string tag, input int aborts);
    repeat (4) @(posedge clk);
    #1;
    chk({tag, " count"}, got_q.size(), exp_q.size());
    foreach (exp_q[j])
      if (j < got_q.size()) chk($sformatf("%s byte%0d", tag, j), got_q[j], exp_q[j]);
    chk({tag, " aborts"}, abort_cnt, aborts);
    chk({tag, " locked"}, locked, 0);
  endtask

  // Restart hunting from an empty window between scenarios.
  task automatic separate();
    sig_det = 1'b0;
    @(posedge clk); #1;
    sig_det = 1'b1;
  endtask

  logic [31:0] p2;

  initial begin
    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst tvalid", data_tvalid, 0);
    chk("rst tdata", data_tdata, 0);
    chk("rst tuser", data_tuser, 0);
    chk("rst tlast", data_tlast, 0);
    chk("rst locked", locked, 0);
    chk("rst inverted", inverted, 0);
    chk("rst abort", frame_abort, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Clean frame.
    want_q.delete(); add_want(32'h12345678, 4);
    prepare(SYNC, 32'h12345678, 32, 1'b0, 32'h0, 1'b0);
    drive(1'b0);
    compare_out("clean", 0);
    chk("clean inverted", inverted, 0);
    separate();

    // Inverted frame.
    want_q.delete(); add_want(32'h12345678, 4);
    prepare(SYNC, 32'h12345678, 32, 1'b0, 32'h0, 1'b1);
    drive(1'b0);
    compare_out("inv", 0);
    chk("inv inverted", inverted, 1);
    separate();

    // One bit error locks.
    want_q.delete(); add_want(32'h12345678, 4);
    prepare(16'hEB91, 32'h12345678, 32, 1'b0, 32'h0, 1'b0);
    drive(1'b0);
    compare_out("err1", 0);
    chk("err1 inverted", inverted, 0);
    separate();

    // Two bit errors do not lock.
    want_q.delete();
    prepare(16'hEB93, 32'h12345678, 32, 1'b0, 32'h0, 1'b0);
    drive(1'b0);
    compare_out("err2", 0);
    chk("err2 strobes", got_q.size(), 0);
    separate();

    // Carrier loss after 2.5 bytes.
    want_q.delete(); add_want(32'h12345678, 2);
    prepare(SYNC, 32'h12345678, 20, 1'b0, 32'h0, 1'b0);
    drive(1'b0);
    chk("cl locked before", locked, 1);
    separate();
    compare_out("carrier", 1);
    foreach (got_q[j]) chk($sformatf("carrier tlast%0d", j), got_q[j][8], 0);

    // Clean frame after the abort.
    want_q.delete(); add_want(32'h12345678, 4);
    prepare(SYNC, 32'h12345678, 32, 1'b0, 32'h0, 1'b0);
    drive(1'b0);
    compare_out("recover", 0);
    separate();

    // Back-to-back frames, bit_vld every other cycle.
    p2 = $urandom;
    want_q.delete(); add_want(32'h12345678, 4); add_want(p2, 4);
    prepare(SYNC, 32'h12345678, 32, 1'b1, p2, 1'b0);
    drive(1'b1);
    compare_out("b2b", 0);
    separate();

    // Asynchronous reset mid-frame.
    want_q.delete(); add_want(32'h12345678, 2);
    prepare(SYNC, 32'h12345678, 20, 1'b0, 32'h0, 1'b1);
    drive(1'b0);
    chk("mid locked", locked, 1);
    chk("mid inverted", inverted, 1);
    chk("mid tdata", data_tdata, 8'h34);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst locked", locked, 0);
    chk("arst inverted", inverted, 0);
    chk("arst tdata", data_tdata, 0);
    chk("arst tvalid", data_tvalid, 0);
    chk("arst tuser", data_tuser, 0);
    chk("arst tlast", data_tlast, 0);
    chk("arst abort", frame_abort, 0);
    #3;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
